// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, fetch
// geometry, buffer entry layout and small address helpers.
package ifetch_unit_pkg;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_FETCH = 3'd1,
    ST_FULL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } if_state_e;

  localparam logic [31:0] INST_BYTES       = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + INST_BYTES;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bundle: redirect input, I-cache CPU-side request port and the
// decode-side instruction port. master = fetch unit, slave = its environment.
interface ifetch_unit_if;

  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] cpu_req_addr;
  logic        cpu_req_valid;
  logic [31:0] cpu_req_data;
  logic        cpu_req_ready;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        misalign_err;

  modport master (
    input  redirect_valid, redirect_pc, cpu_req_data, cpu_req_ready, inst_ready,
    output cpu_req_addr, cpu_req_valid, inst_valid, inst_data, inst_pc, misalign_err
  );

  modport slave (
    output redirect_valid, redirect_pc, cpu_req_data, cpu_req_ready, inst_ready,
    input  cpu_req_addr, cpu_req_valid, inst_valid, inst_data, inst_pc, misalign_err
  );

endinterface

// File: rtl/ifetch_unit_fetch_buf.sv
// Circular FIFO of {pc, inst} entries; flush wins over push/pop, and the head
// entry is read straight from the storage registers.
module fetch_buf
  import ifetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  fetch_entry_t             push_entry_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push_s, do_pop_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);
  assign head_o    = mem_q[head_q];
  assign count_o   = count_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push_s) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (do_pop_s) begin
        head_q <= head_q + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s && !flush_i) begin
      mem_q[tail_q] <= push_entry_i;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: one outstanding I-cache request at a time, redirect
// and flush handling (including draining a miss that cannot be aborted).
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  if_state_e        state_q, state_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic             halt_pend_q, halt_pend_d;
  logic             err_q, err_d;

  logic             req_valid_s, inst_valid_s;
  logic             accept_s, pop_s, push_s, flush_s;
  logic             bad_align_s, drain_halt_s;
  logic [31:0]      drain_tgt_s;
  logic [CNT_W-1:0] count_s;
  logic             full_s, empty_s;
  fetch_entry_t     push_entry_s, head_s;

  assign bad_align_s  = is_misaligned(bus.redirect_pc[1:0]);
  assign accept_s     = req_valid_s & bus.cpu_req_ready;
  assign pop_s        = inst_valid_s & bus.inst_ready;
  assign flush_s      = bus.redirect_valid;
  assign push_s       = accept_s & (state_q == ST_FETCH) & ~bus.redirect_valid;
  assign push_entry_s = '{pc: req_addr_q, inst: bus.cpu_req_data};
  // While draining, the latest redirect seen so far is the one that takes effect.
  assign drain_tgt_s  = bus.redirect_valid ? bus.redirect_pc : pend_pc_q;
  assign drain_halt_s = halt_pend_q | (bus.redirect_valid & bad_align_s);

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buf (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_s),
    .push_entry_i (push_entry_s),
    .pop_i        (pop_s),
    .flush_i      (flush_s),
    .head_o       (head_s),
    .count_o      (count_s),
    .full_o       (full_s),
    .empty_o      (empty_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch address, pending redirect target and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr_q  <= RESET_PC;
      pend_pc_q   <= 32'h0000_0000;
      halt_pend_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      req_addr_q  <= req_addr_d;
      pend_pc_q   <= pend_pc_d;
      halt_pend_q <= halt_pend_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic: HALT is terminal, DRAIN waits out the old request,
  // otherwise a redirect beats normal fetch progress.
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    pend_pc_d   = pend_pc_q;
    halt_pend_d = halt_pend_q;
    err_d       = err_q;
    if (state_q == ST_HALT) begin
      state_d = ST_HALT;
    end else if (state_q == ST_DRAIN) begin
      err_d = err_q | (bus.redirect_valid & bad_align_s);
      if (bus.cpu_req_ready) begin
        req_addr_d = drain_tgt_s;
        state_d    = drain_halt_s ? ST_HALT : ST_FETCH;
      end else begin
        pend_pc_d   = drain_tgt_s;
        halt_pend_d = drain_halt_s;
      end
    end else if (bus.redirect_valid) begin
      err_d = err_q | bad_align_s;
      if (req_valid_s && !bus.cpu_req_ready) begin
        state_d     = ST_DRAIN;
        pend_pc_d   = bus.redirect_pc;
        halt_pend_d = bad_align_s;
      end else begin
        state_d    = bad_align_s ? ST_HALT : ST_FETCH;
        req_addr_d = bus.redirect_pc;
      end
    end else begin
      case (state_q)
        ST_RESET: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (accept_s) begin
            req_addr_d = next_pc(req_addr_q);
            if (!pop_s && (count_s == CNT_W'(BUF_DEPTH - 1))) begin
              state_d = ST_FULL;
            end else begin
              state_d = ST_FETCH;
            end
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_FULL: begin
          if (pop_s) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_RESET;
        end
      endcase
    end
  end

  // Output decode from registered state only.
  always_comb begin
    req_valid_s  = 1'b0;
    inst_valid_s = 1'b0;
    case (state_q)
      ST_FETCH: begin
        req_valid_s  = ~full_s;
        inst_valid_s = ~empty_s;
      end
      ST_FULL: begin
        req_valid_s  = 1'b0;
        inst_valid_s = ~empty_s;
      end
      ST_DRAIN: begin
        req_valid_s  = 1'b1;
        inst_valid_s = 1'b0;
      end
      default: begin
        req_valid_s  = 1'b0;
        inst_valid_s = 1'b0;
      end
    endcase
  end

  assign bus.cpu_req_valid = req_valid_s;
  assign bus.cpu_req_addr  = req_addr_q;
  assign bus.inst_valid    = inst_valid_s;
  assign bus.inst_data     = head_s.inst;
  assign bus.inst_pc       = head_s.pc;
  assign bus.misalign_err  = err_q;

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage directly upstream of the I-cache. Holds the PC, issues one word fetch at a time on the cache's CPU-side request port, and queues returned instructions with their PCs in a small buffer for the decode stage. Handles branch/exception redirects, including a redirect that lands while a cache miss is still outstanding.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- BUF_DEPTH, 2: instruction buffer entries; allowed values are 2 or 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  one-cycle pulse; load a new PC and flush.
- redirect_pc  in  32  redirect target.
- cpu_req_addr  out  32  fetch address to the I-cache.
- cpu_req_valid  out  1  fetch request valid.
- cpu_req_data  in  32  instruction word; valid in the cycle cpu_req_ready=1.
- cpu_req_ready  in  1  request accepted and data returned this cycle.
- inst_valid  out  1  buffer head valid.
- inst_ready  in  1  decode consumes the head.
- inst_data  out  32  head instruction.
- inst_pc  out  32  head PC.
- misalign_err  out  1  sticky; redirect_pc[1:0] was nonzero.

## Operation
- **States:**
  - RESET: entered asynchronously while rst=0.
  - FETCH: issue requests.
  - FULL: buffer full; no request.
  - DRAIN: discard an outstanding request after a redirect.
  - HALT: after a misaligned redirect.
- **RESET → FETCH** on the first edge after rst rises.
- **FETCH:**
  - cpu_req_valid=1 and cpu_req_addr=pc whenever count<BUF_DEPTH.
  - Accept = cpu_req_valid & cpu_req_ready: push {pc, cpu_req_data}, then pc ← pc+4.
  - If the push makes count==BUF_DEPTH and there is no pop in that cycle, go to FULL.
- **FULL:** cpu_req_valid=0. Return to FETCH on the edge after any pop.
- **Handshake rule:** once cpu_req_valid is 1, cpu_req_valid and cpu_req_addr stay stable until cpu_req_ready. The cache miss path cannot be aborted. Space is reserved before issuing because pops only ever free space.
- **Redirect (takes priority over everything except reset):**
  - Flush the buffer (count ← 0).
  - pc ← redirect_pc.
  - If a request is outstanding and not accepted this cycle, go to DRAIN and keep the old address stable.
  - Otherwise go to FETCH.
  - A redirect in the same cycle as an accept discards the accepted word.
- **DRAIN:**
  - Hold the old request until ready, discard its data, then go to FETCH with the redirect PC.
  - A further redirect during DRAIN overwrites the pending PC (latest wins).
- **Misaligned redirect (redirect_pc[1:0]≠0):**
  - Set misalign_err, flush, go to HALT.
  - If a request is outstanding, go to DRAIN first, then HALT.
  - HALT: cpu_req_valid=0, inst_valid=0. Only reset exits.
- **Buffer:** circular, with head/tail pointers of log2(BUF_DEPTH) bits that wrap naturally, plus a count of log2(BUF_DEPTH)+1 bits. Simultaneous push and pop leaves count unchanged.
- **PC arithmetic:** 32-bit and wraps 32'hFFFF_FFFC → 0 silently.

## Timing
- **Reset values:**
  - cpu_req_valid=0, cpu_req_addr=RESET_PC.
  - inst_valid=0, inst_data=0, inst_pc=0.
  - misalign_err=0, count=0.
- **First request:** cpu_req_valid rises in the first cycle after the first edge following rst release.
- **Accept-to-head latency:** a word accepted at edge N appears at the buffer head with inst_valid=1 after edge N (registered buffer). It is visible to decode one cycle after cpu_req_ready.
- **Back-to-back hits** (cache ready in the same cycle as the request) sustain one fetch per cycle while space remains.
- **Flush timing:** a redirect pulse at edge N drives inst_valid=0 from N until new data arrives. cpu_req_addr=redirect_pc from N when not draining.
- **Reset mid-miss:** all state clears immediately (asynchronous). The cache is reset by the same rst.

## Structure
- Shared header IF_Stage.vh, alongside the cache's state header, holds:
  - state encodings (RESET, FETCH, FULL, DRAIN, HALT);
  - INST_BYTES=4;
  - the default RESET_PC.
- Sub-module fetch_buf: parameterised FIFO of {pc, inst} with push, pop, flush, count, full and empty.

## Test plan
- Reset release with the cache always ready and inst_ready=1 → cpu_req_addr sequence 0, 4, 8, 12 on consecutive cycles; inst_pc follows one cycle behind.
- inst_ready=0 and BUF_DEPTH=2 → exactly two accepts (PC 0, 4), then cpu_req_valid=0. Raise inst_ready → fetch resumes at PC 8.
- Cache ready delayed 5 cycles on the request to 0x10, redirect to 0x100 at cycle 2:
  - cpu_req_addr stays 0x10 until ready;
  - data for 0x10 never reaches inst_valid;
  - the next request address is 0x100.
- Two redirects during DRAIN (0x200 then 0x300) → the next fetch is 0x300.
- Redirect to 0x102 → misalign_err=1, no further requests, inst_valid=0 until rst is asserted.
- Assert rst during an outstanding miss → all outputs return to reset values in the same cycle, and fetch restarts at RESET_PC.
